program_loader: RTL and testbench



---
 rtl/program_loader.sv | 138 +++++++++++++
 tb/tb_program_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Receives a framed program image over a byte stream, writes it into instruction
// memory with the CPU stalled, then loads the entry PC once the checksum matches.
module program_loader #(
  parameter int ADDR_W  = 8,
  parameter int CSUM_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_stall,
  output logic              pc_load_n,
  output logic [ADDR_W-1:0] pc_load_val,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        fsm_state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HDR_BASE  = 3'd1;
  localparam logic [2:0] S_HDR_LEN   = 3'd2;
  localparam logic [2:0] S_HDR_ENTRY = 3'd3;
  localparam logic [2:0] S_DATA      = 3'd4;
  localparam logic [2:0] S_CSUM      = 3'd5;
  localparam logic [2:0] S_LOAD_PC   = 3'd6;

  // Stream handshake: a byte transfers on a rising edge where byte_valid and
  // byte_ready are both high; byte_ready is registered and high only in receive states.
  logic [2:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        count;
  logic [7:0]        csum;
  logic              take;

  assign take      = byte_valid && byte_ready;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      count       <= 8'd0;
      csum        <= 8'd0;
      byte_ready  <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 8'd0;
      cpu_stall   <= 1'b0;
      pc_load_n   <= 1'b1;
      pc_load_val <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      done      <= 1'b0;
      pc_load_n <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_HDR_BASE;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            cpu_stall  <= 1'b1;
            err        <= 1'b0;
            csum       <= 8'd0;
          end
        end
        S_HDR_BASE: begin
          if (take) begin
            ptr   <= ADDR_W'(byte_in);
            csum  <= csum ^ byte_in;
            state <= S_HDR_LEN;
          end
        end
        S_HDR_LEN: begin
          if (take) begin
            count <= byte_in;
            csum  <= csum ^ byte_in;
            state <= S_HDR_ENTRY;
          end
        end
        S_HDR_ENTRY: begin
          if (take) begin
            pc_load_val <= ADDR_W'(byte_in);
            csum        <= csum ^ byte_in;
            state       <= (count != 8'd0) ? S_DATA : S_CSUM;
          end
        end
        S_DATA: begin
          // The write lands one cycle after the byte is accepted.
          if (take) begin
            imem_we    <= 1'b1;
            imem_addr  <= ptr;
            imem_wdata <= byte_in;
            ptr        <= ptr + ADDR_W'(1);
            count      <= count - 8'd1;
            csum       <= csum ^ byte_in;
            if (count == 8'd1) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (take) begin
            byte_ready <= 1'b0;
            if ((byte_in == csum) || (CSUM_EN == 0)) begin
              state     <= S_LOAD_PC;
              pc_load_n <= 1'b0;
            end else begin
              state     <= S_IDLE;
              err       <= 1'b1;
              busy      <= 1'b0;
              cpu_stall <= 1'b0;
            end
          end
        end
        S_LOAD_PC: begin
          state     <= S_IDLE;
          done      <= 1'b1;
          busy      <= 1'b0;
          cpu_stall <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          cpu_stall  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: two instances (checksum checked / ignored)
// share one byte stream; a frame-level model predicts writes, PC loads, done and err.
module tb_program_loader;

  localparam logic [1:0] EV_WR   = 2'd0;
  localparam logic [1:0] EV_PC   = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;
  localparam logic [1:0] EV_ERR  = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] byte_in = 8'd0;
  logic       byte_valid = 1'b0;

  logic       byte_ready, imem_we, cpu_stall, pc_load_n, busy, done, err;
  logic [7:0] imem_addr, imem_wdata, pc_load_val;
  logic [2:0] fsm_state;
  logic       byte_ready_nc, imem_we_nc, cpu_stall_nc, pc_load_n_nc, busy_nc, done_nc, err_nc;
  logic [7:0] imem_addr_nc, imem_wdata_nc, pc_load_val_nc;
  logic [2:0] fsm_state_nc;

  program_loader #(.ADDR_W(8), .CSUM_EN(1)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_stall(cpu_stall), .pc_load_n(pc_load_n), .pc_load_val(pc_load_val),
    .busy(busy), .done(done), .err(err), .fsm_state(fsm_state)
  );

  program_loader #(.ADDR_W(8), .CSUM_EN(0)) dut_nc (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready_nc), .imem_we(imem_we_nc), .imem_addr(imem_addr_nc),
    .imem_wdata(imem_wdata_nc), .cpu_stall(cpu_stall_nc), .pc_load_n(pc_load_n_nc),
    .pc_load_val(pc_load_val_nc), .busy(busy_nc), .done(done_nc), .err(err_nc),
    .fsm_state(fsm_state_nc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp_q_nc[$];
  logic [7:0]  frame_q[$];
  bit   mon_on = 1'b0;
  logic err_q = 1'b0;
  logic err_q_nc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_compare(input bit nc, input logic [17:0] act);
    logic [17:0] exp;
    if ((nc ? exp_q_nc.size() : exp_q.size()) == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected event %h, nothing expected", nc ? "sb_nc" : "sb", act);
    end else begin
      exp = nc ? exp_q_nc.pop_front() : exp_q.pop_front();
      check(nc ? "sb_nc_event" : "sb_event", 64'(act), 64'(exp));
    end
  endtask

  // Monitor: every observable event is matched against the head of its queue.
  always @(negedge clk) begin
    if (mon_on) begin
      if (imem_we) sb_compare(1'b0, {EV_WR, imem_addr, imem_wdata});
      if (!pc_load_n) begin
        sb_compare(1'b0, {EV_PC, pc_load_val, 8'h00});
        check("stall_during_load", 64'({busy, cpu_stall}), 64'(2'b11));
      end
      if (done) begin
        sb_compare(1'b0, {EV_DONE, 16'h0000});
        check("released_at_done", 64'({busy, cpu_stall}), 64'(2'b00));
      end
      if (err && !err_q) sb_compare(1'b0, {EV_ERR, 16'h0000});
      err_q = err;
      if (imem_we_nc) sb_compare(1'b1, {EV_WR, imem_addr_nc, imem_wdata_nc});
      if (!pc_load_n_nc) sb_compare(1'b1, {EV_PC, pc_load_val_nc, 8'h00});
      if (done_nc) sb_compare(1'b1, {EV_DONE, 16'h0000});
      if (err_nc && !err_q_nc) sb_compare(1'b1, {EV_ERR, 16'h0000});
      err_q_nc = err_nc;
    end
  end

  task automatic check_reset_vals(input string name);
    logic [33:0] exp;
    exp = {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0};
    check(name, 64'({byte_ready, imem_we, imem_addr, imem_wdata, cpu_stall, pc_load_n,
                     pc_load_val, busy, done, err, fsm_state}), 64'(exp));
    check({name, "_nc"}, 64'({byte_ready_nc, imem_we_nc, imem_addr_nc, imem_wdata_nc,
                              cpu_stall_nc, pc_load_n_nc, pc_load_val_nc, busy_nc, done_nc,
                              err_nc, fsm_state_nc}), 64'(exp));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("after_start", 64'({busy, cpu_stall, byte_ready, err}), 64'(4'b1110));
    check("after_start_nc", 64'({busy_nc, cpu_stall_nc, byte_ready_nc, err_nc}), 64'(4'b1110));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max, input bit spam);
    int gap;
    int t;
    gap = $urandom_range(0, gap_max);
    repeat (gap) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      start      = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    start      = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    t = 0;
    while (!byte_ready && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (t >= 30) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: byte_ready stayed 0, required 1");
    end
    @(negedge clk);
  endtask

  // Model works at frame level: data bytes land at base+i (mod 256), the PC loads
  // the entry value when the XOR of every byte before the checksum matches it.
  task automatic run_frame(input int gap_max, input bit spam, input int abort_at);
    int n;
    int nbytes;
    int t;
    logic [7:0] x;
    logic [7:0] entry;
    bit good;
    n     = int'(frame_q[1]);
    entry = frame_q[2];
    x     = frame_q[0] ^ frame_q[1] ^ frame_q[2];
    for (int i = 0; i < n; i++) x ^= frame_q[3 + i];
    good   = (frame_q[3 + n] == x);
    nbytes = (abort_at >= 0) ? abort_at : frame_q.size();
    for (int i = 0; i < n; i++) begin
      if (3 + i < nbytes) begin
        exp_q.push_back({EV_WR, frame_q[0] + 8'(i), frame_q[3 + i]});
        exp_q_nc.push_back({EV_WR, frame_q[0] + 8'(i), frame_q[3 + i]});
      end
    end
    if (abort_at < 0) begin
      if (good) begin
        exp_q.push_back({EV_PC, entry, 8'h00});
        exp_q.push_back({EV_DONE, 16'h0000});
      end else begin
        exp_q.push_back({EV_ERR, 16'h0000});
      end
      exp_q_nc.push_back({EV_PC, entry, 8'h00});
      exp_q_nc.push_back({EV_DONE, 16'h0000});
    end

    do_start();
    for (int i = 0; i < nbytes; i++) send_byte(frame_q[i], gap_max, spam);
    byte_valid = 1'b0;

    if (abort_at >= 0) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_vals("reset_mid_load");
      check("abort_events", 64'(exp_q.size() + exp_q_nc.size()), 64'(0));
      exp_q.delete();
      exp_q_nc.delete();
    end else begin
      t = 0;
      while ((busy || busy_nc) && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) begin
        n_cmp++;
        n_bad++;
        $display("FAIL idle_timeout: busy stayed 1, required 0");
      end
      @(negedge clk);
      check("frame_events", 64'(exp_q.size()), 64'(0));
      check("frame_events_nc", 64'(exp_q_nc.size()), 64'(0));
      check("post_frame", 64'({busy, cpu_stall, byte_ready, done, err, pc_load_n, pc_load_val}),
            64'({1'b0, 1'b0, 1'b0, 1'b0, !good, 1'b1, entry}));
      check("post_frame_nc", 64'({busy_nc, cpu_stall_nc, byte_ready_nc, done_nc, err_nc,
                                  pc_load_n_nc, pc_load_val_nc}),
            64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, entry}));
      exp_q.delete();
      exp_q_nc.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    logic [7:0] x;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_values");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("idle_after_reset");
    mon_on = 1'b1;

    frame_q = {8'h10, 8'h02, 8'h10, 8'hAA, 8'h55, 8'hFD};
    run_frame(0, 1'b0, -1);
    frame_q = {8'h10, 8'h02, 8'h10, 8'hAA, 8'h55, 8'h00};
    run_frame(0, 1'b0, -1);
    frame_q = {8'hFF, 8'h02, 8'h05, 8'h11, 8'h22, 8'hCB};
    run_frame(0, 1'b0, -1);
    frame_q = {8'h20, 8'h00, 8'h07, 8'h27};
    run_frame(0, 1'b0, -1);
    frame_q = {8'h10, 8'h02, 8'h10, 8'hAA, 8'h55, 8'hFD};
    run_frame(5, 1'b1, -1);
    run_frame(0, 1'b0, 4);
    run_frame(0, 1'b0, -1);

    for (int k = 0; k < 10; k++) begin
      frame_q.delete();
      n = $urandom_range(0, 10);
      frame_q.push_back(8'($urandom));
      frame_q.push_back(8'(n));
      frame_q.push_back(8'($urandom));
      for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
      x = 8'h00;
      foreach (frame_q[i]) x ^= frame_q[i];
      if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
      frame_q.push_back(x);
      run_frame(3, 1'b1, -1);
    end

    repeat (5) @(negedge clk);
    check("final_drain", 64'(exp_q.size() + exp_q_nc.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
